// File: rtl/regfile_dump.sv
// regfile_dump: sweeps a register file read port and streams each register out as a valid/ready beat.
// Optional trailing XOR checksum beat when REGFILE_DUMP_CHKSUM_EN is defined.
module regfile_dump #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ra,
    input  logic [DW-1:0] rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_idx,
    output logic          out_last
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

`ifdef REGFILE_DUMP_CHKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_DONE,
        S_CHK
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_DONE
    } state_t;
`endif

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [DW-1:0] data_q, data_d;
    logic [AW-1:0] oidx_q, oidx_d;
    logic          last_q, last_d;
`ifdef REGFILE_DUMP_CHKSUM_EN
    logic [DW-1:0] xor_q, xor_d;
`endif

    // Next-state, beat capture and handshake outputs.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        oidx_d    = oidx_q;
        last_d    = last_q;
`ifdef REGFILE_DUMP_CHKSUM_EN
        xor_d     = xor_q;
`endif
        busy      = (state_q != S_IDLE);
        done      = 1'b0;
        out_valid = 1'b0;
        ra        = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = '0;
`ifdef REGFILE_DUMP_CHKSUM_EN
                    xor_d   = '0;
`endif
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ra      = idx_q;
                data_d  = rd;
                oidx_d  = idx_q;
`ifdef REGFILE_DUMP_CHKSUM_EN
                last_d  = 1'b0;
                xor_d   = xor_q ^ rd;
`else
                last_d  = (idx_q == LAST_IDX);
`endif
                state_d = S_SEND;
            end
            S_SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (idx_q < LAST_IDX) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_FETCH;
                    end else begin
`ifdef REGFILE_DUMP_CHKSUM_EN
                        data_d  = xor_q;
                        oidx_d  = '0;
                        last_d  = 1'b1;
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end
`ifdef REGFILE_DUMP_CHKSUM_EN
            S_CHK: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and beat registers; reset aborts any dump in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            oidx_q  <= '0;
            last_q  <= 1'b0;
`ifdef REGFILE_DUMP_CHKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            oidx_q  <= oidx_d;
            last_q  <= last_d;
`ifdef REGFILE_DUMP_CHKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

    assign out_data = data_q;
    assign out_idx  = oidx_q;
    assign out_last = last_q;

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed self-checking bench for regfile_dump.
// Works with or without REGFILE_DUMP_CHKSUM_EN defined.
module tb_regfile_dump;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [4:0]  ra;
    logic [31:0] rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_idx;
    logic        out_last;

    logic [31:0] rf [32];
    logic [31:0] exp_d [34];
    logic [4:0]  exp_i [34];
    logic        exp_l [34];
    int          nexp;
    int          checks;
    int          errors;
    int          nb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rd = rf[ra];

    regfile_dump #(
        .NREGS(32),
        .AW   (5),
        .DW   (32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .ra       (ra),
        .rd       (rd),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_idx  (out_idx),
        .out_last (out_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected beat list built straight from the register-file image.
    task automatic build_exp();
        logic [31:0] x;
        x = '0;
        for (int i = 0; i < 32; i++) begin
            exp_d[i] = rf[i];
            exp_i[i] = 5'(i);
            exp_l[i] = (i == 31);
            x = x ^ rf[i];
        end
        nexp = 32;
`ifdef REGFILE_DUMP_CHKSUM_EN
        exp_l[31] = 1'b0;
        exp_d[32] = x;
        exp_i[32] = '0;
        exp_l[32] = 1'b1;
        nexp = 33;
`endif
    endtask

    task automatic begin_dump();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("fetch_busy", 32'(busy), 32'd1);
        chk("fetch_valid", 32'(out_valid), 32'd0);
        chk("fetch_ra", 32'(ra), 32'd0);
        step();
        chk("latency_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic collect(input int rmode, input int wr_mid, input int st_mid,
                           input int stop_idx, output int nbo);
        int          cyc;
        int          hs_cyc;
        bit          stall;
        bit          wrote;
        bit          seen;
        logic [31:0] pd;
        logic [4:0]  pi;
        cyc = 0;
        hs_cyc = -10;
        stall = 0;
        wrote = 0;
        seen = 0;
        pd = '0;
        pi = '0;
        nbo = 0;
        while (cyc < 400) begin
            if (done) begin
                seen = 1;
                break;
            end
            out_ready = (rmode == 0) ? 1'b1 : ((cyc % 3) == 2);
            if (stall) begin
                chk("hold_data", out_data, pd);
                chk("hold_idx", 32'(out_idx), 32'(pi));
            end
            if (out_valid && int'(out_idx) == stop_idx) begin
                return;
            end
            if (out_valid) begin
                chk("ra_send", 32'(ra), 32'd0);
            end
            start = (st_mid != 0 && nbo == 10);
            if (wr_mid != 0 && !wrote && out_valid && out_idx == 5'd10) begin
                rf[3] = 32'hDEAD0003;
                rf[20] = 32'hBEEF0014;
                wrote = 1;
            end
            if (out_valid && out_ready) begin
                if (nbo < nexp) begin
                    chk("beat_data", out_data, exp_d[nbo]);
                    chk("beat_idx", 32'(out_idx), 32'(exp_i[nbo]));
                    chk("beat_last", 32'(out_last), 32'(exp_l[nbo]));
                end else begin
                    chk("extra_beat", 32'(nbo), 32'(nexp));
                end
                nbo++;
                hs_cyc = cyc;
            end
            stall = out_valid && !out_ready;
            pd = out_data;
            pi = out_idx;
            step();
            cyc++;
        end
        start = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        if (!seen) begin
            return;
        end
        chk("beat_count", 32'(nbo), 32'(nexp));
        chk("done_latency", 32'(cyc - hs_cyc), 32'd1);
        chk("done_valid", 32'(out_valid), 32'd0);
        chk("done_busy", 32'(busy), 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("done_pulse", 32'(done), 32'd0);
        chk("busy_fall", 32'(busy), 32'd0);
        step();
        chk("done_start_ign", 32'(busy), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        start = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h01010101;
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_idx", 32'(out_idx), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_ra", 32'(ra), 32'd0);
        step();
        chk("rst_start_ign", 32'(busy), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        build_exp();
        begin_dump();
        collect(0, 0, 0, 99, nb);

        begin_dump();
        collect(1, 0, 0, 99, nb);

        begin_dump();
        collect(0, 0, 1, 99, nb);

        build_exp();
`ifdef REGFILE_DUMP_CHKSUM_EN
        exp_d[32] = exp_d[32] ^ rf[20] ^ 32'hBEEF0014;
`endif
        exp_d[20] = 32'hBEEF0014;
        begin_dump();
        collect(1, 1, 0, 99, nb);
        rf[3] = 32'h03030303;
        rf[20] = 32'h14141414;

        build_exp();
        begin_dump();
        collect(1, 0, 0, 17, nb);
        chk("mid_valid_pre", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_ra", 32'(ra), 32'd0);
        chk("async_data", out_data, 32'd0);
        chk("async_idx", 32'(out_idx), 32'd0);
        step();
        chk("abort_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_nodone", 32'(done), 32'd0);
        step();
        chk("abort_idle2", 32'(busy), 32'd0);
        begin_dump();
        collect(0, 0, 0, 99, nb);

        for (int i = 0; i < 32; i++) rf[i] = 32'(i);
        build_exp();
`ifdef REGFILE_DUMP_CHKSUM_EN
        chk("model_xor_ramp", exp_d[32], 32'h00000000);
`endif
        begin_dump();
        collect(0, 0, 0, 99, nb);

        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[5] = 32'hFFFFFFFF;
        build_exp();
`ifdef REGFILE_DUMP_CHKSUM_EN
        chk("model_xor_r5", exp_d[32], 32'hFFFFFFFF);
`endif
        begin_dump();
        collect(1, 0, 0, 99, nb);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
